// File: rtl/vib_alarm_pkg.sv
// Shared types and helpers for the multi-channel vibration alarm judge.
package vib_alarm_pkg;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_HIGH = 2'd2
  } alarm_lvl_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/vib_alarm_judge_mc_if.sv
// Bus bundle between the max/min trackers, the alarm judge and the report logic.
// The judge connects through the slave modport; the source side uses master.
interface vib_alarm_judge_mc_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned DW = 16
);
  logic [CH*DW-1:0] dat_max;
  logic [CH*DW-1:0] dat_min;
  logic             dat_limit_en;
  logic [CH-1:0]    alarm_ack;
  logic [CH-1:0]    alarm;
  logic [2*CH-1:0]  alarm_level;
  logic             alarm_any;

  modport master (
    output dat_max, dat_min, dat_limit_en, alarm_ack,
    input  alarm, alarm_level, alarm_any
  );

  modport slave (
    input  dat_max, dat_min, dat_limit_en, alarm_ack,
    output alarm, alarm_level, alarm_any
  );
endinterface

// File: rtl/vib_alarm_chan.sv
// One alarm channel: peak-to-peak amplitude, consecutive-window counters and level FSM.
// Optional auto-clear after a run of quiet windows: VIB_ALARM_AUTO_CLEAR_EN.
//
//   state     | meaning
//   LVL_NONE  | no alarm
//   LVL_LOW   | lcnt reached LOW_CNT, waiting for ack (or escalation to HIGH)
//   LVL_HIGH  | hcnt reached HIGH_CNT, held until ack; never downgraded directly
module vib_alarm_chan
  import vib_alarm_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HIGH_THR = 32'h0000_A000,
  parameter int unsigned HIGH_CNT = 10,
  parameter int unsigned LOW_THR  = 32'h0000_4000,
  parameter int unsigned LOW_CNT  = 5
`ifdef VIB_ALARM_AUTO_CLEAR_EN
  , parameter int unsigned CLR_CNT = 20
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          win,
  input  logic [DW-1:0] dat_max,
  input  logic [DW-1:0] dat_min,
  input  logic          ack,
  output alarm_lvl_t    level,
  output logic          alarm
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic [DW-1:0]    pp;
  logic             hi_hit, lo_hit;
  logic [CNT_W-1:0] hcnt, lcnt;
  logic             upd;
  logic             entry_high, entry_low;
  logic             clr;
  alarm_lvl_t       state, state_nxt;
`ifdef VIB_ALARM_AUTO_CLEAR_EN
  logic [CNT_W-1:0] qcnt;
`endif

  // Peak-to-peak clamps to zero when the tracker reports min above max.
  assign pp     = (dat_max >= dat_min) ? (dat_max - dat_min) : '0;
  assign hi_hit = pp >= DW'(HIGH_THR);
  assign lo_hit = pp >= DW'(LOW_THR);

  assign entry_high = hcnt >= CNT_W'(HIGH_CNT);
  assign entry_low  = (lcnt >= CNT_W'(LOW_CNT)) && !entry_high;

  // Window counters; an ack/auto-clear takes precedence over a coincident window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      lcnt <= '0;
      upd  <= 1'b0;
`ifdef VIB_ALARM_AUTO_CLEAR_EN
      qcnt <= '0;
`endif
    end else begin
      upd <= win;
      if (clr) begin
        hcnt <= '0;
        lcnt <= '0;
`ifdef VIB_ALARM_AUTO_CLEAR_EN
        qcnt <= '0;
`endif
      end else if (win) begin
        hcnt <= hi_hit ? CNT_W'(sat_inc(32'(hcnt), CNT_MAX)) : '0;
        lcnt <= lo_hit ? CNT_W'(sat_inc(32'(lcnt), CNT_MAX)) : '0;
`ifdef VIB_ALARM_AUTO_CLEAR_EN
        qcnt <= lo_hit ? '0 : CNT_W'(sat_inc(32'(qcnt), CNT_MAX));
`endif
      end
    end
  end

  // Level state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LVL_NONE;
    else        state <= state_nxt;
  end

  // Next level. An ack only loses to an entry condition freshly produced by the
  // previous window; stale counters left over from the alarm do not block it.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      LVL_NONE: begin
        if (entry_high)     state_nxt = LVL_HIGH;
        else if (entry_low) state_nxt = LVL_LOW;
      end
      LVL_LOW: begin
        if (entry_high) state_nxt = LVL_HIGH;
      end
      default: state_nxt = LVL_HIGH;
    endcase
    if (ack) begin
      if (upd && entry_high)     state_nxt = LVL_HIGH;
      else if (upd && entry_low) state_nxt = LVL_LOW;
      else begin
        state_nxt = LVL_NONE;
        clr       = 1'b1;
      end
    end
`ifdef VIB_ALARM_AUTO_CLEAR_EN
    if (qcnt >= CNT_W'(CLR_CNT)) begin
      state_nxt = LVL_NONE;
      clr       = 1'b1;
    end
`endif
  end

  assign level = state;
  assign alarm = (state != LVL_NONE);

endmodule

// File: rtl/vib_alarm_judge_mc.sv
// Multi-channel vibration alarm judge: shared window-edge detect, CH independent
// channel judges, and the any-alarm summary.
// Optional auto-clear after quiet windows: VIB_ALARM_AUTO_CLEAR_EN.
// CH/DW must match the parameters of the connected interface instance.
module vib_alarm_judge_mc
  import vib_alarm_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned DW       = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HIGH_THR = 32'h0000_A000,
  parameter int unsigned HIGH_CNT = 10,
  parameter int unsigned LOW_THR  = 32'h0000_4000,
  parameter int unsigned LOW_CNT  = 5
`ifdef VIB_ALARM_AUTO_CLEAR_EN
  , parameter int unsigned CLR_CNT = 20
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  vib_alarm_judge_mc_if.slave bus
);

  logic            en_d;
  logic            win;
  logic [CH-1:0]   alarm_vec;
  logic [2*CH-1:0] level_vec;
  alarm_lvl_t      lvl [CH];

  // Delayed window-valid for rising-edge detection; a held level is one window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_d <= 1'b0;
    else        en_d <= bus.dat_limit_en;
  end

  assign win = bus.dat_limit_en & ~en_d;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    vib_alarm_chan #(
      .DW       (DW),
      .CNT_W    (CNT_W),
      .HIGH_THR (HIGH_THR),
      .HIGH_CNT (HIGH_CNT),
      .LOW_THR  (LOW_THR),
      .LOW_CNT  (LOW_CNT)
`ifdef VIB_ALARM_AUTO_CLEAR_EN
      , .CLR_CNT (CLR_CNT)
`endif
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .win     (win),
      .dat_max (bus.dat_max[i*DW +: DW]),
      .dat_min (bus.dat_min[i*DW +: DW]),
      .ack     (bus.alarm_ack[i]),
      .level   (lvl[i]),
      .alarm   (alarm_vec[i])
    );
    assign level_vec[2*i +: 2] = lvl[i];
  end

  assign bus.alarm       = alarm_vec;
  assign bus.alarm_level = level_vec;
  assign bus.alarm_any   = |alarm_vec;

endmodule

// File: tb/tb_vib_alarm_judge_mc.sv
// Directed bench for vib_alarm_judge_mc; expected levels are hand-computed.
module tb_vib_alarm_judge_mc;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  vib_alarm_judge_mc_if #(.CH(4), .DW(16)) bus ();

  vib_alarm_judge_mc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [15:0] mx, input logic [15:0] mn);
    bus.dat_max[ch*16 +: 16] = mx;
    bus.dat_min[ch*16 +: 16] = mn;
  endtask

  // One window pulse; returns at the negedge after the level has had its clk to update.
  task automatic window();
    @(negedge clk) bus.dat_limit_en = 1'b1;
    @(negedge clk) bus.dat_limit_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic windows(input int n);
    for (int k = 0; k < n; k++) window();
  endtask

  // Window whose level-update edge coincides with an ack.
  task automatic window_ack(input logic [3:0] mask);
    @(negedge clk) bus.dat_limit_en = 1'b1;
    @(negedge clk) begin bus.dat_limit_en = 1'b0; bus.alarm_ack = mask; end
    @(negedge clk) bus.alarm_ack = '0;
  endtask

  task automatic ack_only(input logic [3:0] mask);
    @(negedge clk) bus.alarm_ack = mask;
    @(negedge clk) bus.alarm_ack = '0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.dat_max      = '0;
    bus.dat_min      = '0;
    bus.dat_limit_en = 1'b0;
    bus.alarm_ack    = '0;
    repeat (3) @(negedge clk);
    check("reset_level", 32'(bus.alarm_level), 32'h0);
    check("reset_alarm", 32'(bus.alarm), 32'h0);
    check("reset_any", 32'(bus.alarm_any), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ch0 pp=B000 -> LOW at 5, HIGH at 10
    set_ch(0, 16'hB000, 16'h0000);
    windows(4);
    check("t1_none_at4", 32'(bus.alarm_level), 32'h00);
    window();
    check("t1_low_at5", 32'(bus.alarm_level), 32'h01);
    check("t1_any_at5", 32'(bus.alarm_any), 32'h1);
    windows(4);
    check("t1_low_at9", 32'(bus.alarm_level), 32'h01);
    window();
    check("t1_high_at10", 32'(bus.alarm_level), 32'h02);
    check("t1_alarm_vec", 32'(bus.alarm), 32'h1);
    check("t1_any", 32'(bus.alarm_any), 32'h1);

    // 4: ack with no window clears; ack coinciding with re-qualification keeps HIGH
    ack_only(4'b0001);
    check("t4_ack_clear", 32'(bus.alarm_level), 32'h00);
    check("t4_ack_any", 32'(bus.alarm_any), 32'h0);
    windows(9);
    check("t4_low_after_clear", 32'(bus.alarm_level), 32'h01);
    window();
    check("t4_high_again", 32'(bus.alarm_level), 32'h02);
    window_ack(4'b0001);
    check("t4_ack_requal", 32'(bus.alarm_level), 32'h02);
    ack_only(4'b0001);
    check("t4_ack_final", 32'(bus.alarm_level), 32'h00);
    set_ch(0, 16'h0000, 16'h0000);

    // 2: ch1 pp=5000 x4, break, x5 -> LOW only after the 9th window
    set_ch(1, 16'h5000, 16'h0000);
    windows(4);
    check("t2_none_at4", 32'(bus.alarm_level), 32'h00);
    set_ch(1, 16'h1000, 16'h0000);
    window();
    check("t2_none_break", 32'(bus.alarm_level), 32'h00);
    set_ch(1, 16'h5000, 16'h0000);
    windows(4);
    check("t2_none_at8", 32'(bus.alarm_level), 32'h00);
    window();
    check("t2_low_at9", 32'(bus.alarm_level), 32'h04);
    set_ch(1, 16'h0000, 16'h0000);

    // 3: ch2 min above max -> pp=0, never alarms
    set_ch(2, 16'h0100, 16'h0200);
    windows(10);
    check("t3_no_wrap", 32'(bus.alarm_level), 32'h04);
    set_ch(2, 16'h0000, 16'h0000);

    // 5: reset mid-burst, then held en level counts once
    set_ch(0, 16'hB000, 16'h0000);
    windows(7);
    check("t5_any_before", 32'(bus.alarm_any), 32'h1);
    @(negedge clk) bus.dat_limit_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_level", 32'(bus.alarm_level), 32'h00);
    check("t5_async_any", 32'(bus.alarm_any), 32'h0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.dat_limit_en = 1'b0;
    check("t5_after_rst", 32'(bus.alarm_level), 32'h00);
    windows(8);
    check("t5_low_at9", 32'(bus.alarm_level), 32'h01);
    window();
    check("t5_high_at10", 32'(bus.alarm_level), 32'h02);
    set_ch(0, 16'h0000, 16'h0000);

    // 6: ch3 LOW, then quiet windows
    set_ch(3, 16'h5000, 16'h0000);
    windows(5);
    check("t6_ch3_low", 32'(bus.alarm_level[7:6]), 32'h1);
    set_ch(3, 16'h0100, 16'h0000);
    windows(19);
    check("t6_ch3_low_q19", 32'(bus.alarm_level[7:6]), 32'h1);
    window();
`ifdef VIB_ALARM_AUTO_CLEAR_EN
    check("t6_ch3_autoclr", 32'(bus.alarm_level[7:6]), 32'h0);
`else
    check("t6_ch3_held", 32'(bus.alarm_level[7:6]), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
